// File: rtl/axi_wr_burst_slave.sv
// axi_wr_burst_slave: write half of the AXI4 memory model.
// Accepts one write burst at a time on AW, stores its W beats into an
// internal word memory and answers on B. FIXED, INCR and WRAP burst
// addresses are generated internally. Protocol and range problems are
// reported as SLVERR.
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   aw*                    write address channel (valid/ready handshake)
//   w*                     write data channel (valid/ready handshake)
//   b*                     write response channel (valid/ready handshake)
//   dbg_addr / dbg_rdata   debug word read, data registered one cycle later
module axi_wr_burst_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter int MEM_DEPTH = 128,
  localparam int BPW      = DATA_W / 8,
  localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BPW-1:0]    wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int          SZ_MAX    = $clog2(BPW);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * BPW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [ID_W-1:0]   id_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt_r;
  logic [2:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        burst_r;
  logic              err_r;

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  logic [ADDR_W-1:0] aw_bytes_s;
  logic              wrap_len_ok_s;
  logic              aw_err_s;
  logic [ADDR_W-1:0] bytes_s;
  logic [ADDR_W-1:0] span_s;
  logic [ADDR_W-1:0] lower_s;
  logic [ADDR_W-1:0] inc_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic              beat_s;
  logic              last_s;
  logic              wlast_err_s;
  logic              in_range_s;
  logic              we_s;
  logic [IDX_W-1:0]  widx_s;

  // Address-phase error check, evaluated on the incoming AW fields.
  always_comb begin
    aw_bytes_s    = ADDR_W'(1) << awsize;
    wrap_len_ok_s = (awlen == LEN_W'(1)) | (awlen == LEN_W'(3)) |
                    (awlen == LEN_W'(7)) | (awlen == LEN_W'(15));
    aw_err_s      = (awsize > 3'(SZ_MAX)) |
                    (awburst == 2'b11) |
                    ((awburst == 2'b10) & ~wrap_len_ok_s) |
                    ((awburst == 2'b10) &
                     ((awaddr & (aw_bytes_s - ADDR_W'(1))) != ADDR_W'(0)));
  end

  // Next beat address for the captured burst type.
  always_comb begin
    bytes_s = ADDR_W'(1) << size_r;
    span_s  = (ADDR_W'(len_r) + ADDR_W'(1)) << size_r;
    lower_s = addr_r & ~(span_s - ADDR_W'(1));
    inc_s   = addr_r + bytes_s;
    case (burst_r)
      2'b00: next_addr_s = addr_r;
      2'b01: next_addr_s = (addr_r & ~(bytes_s - ADDR_W'(1))) + bytes_s;
      2'b10: begin
        // WRAP folds back to the bottom of the span when it would leave it
        if (inc_s == lower_s + span_s) begin
          next_addr_s = lower_s;
        end else begin
          next_addr_s = inc_s;
        end
      end
      default: next_addr_s = addr_r;
    endcase
  end

  // Per-beat qualifiers; writes use the error flag as it stood before this beat.
  always_comb begin
    beat_s      = (state_r == DATA) & wvalid & wready;
    last_s      = (cnt_r == len_r);
    wlast_err_s = (wlast != last_s);
    in_range_s  = (addr_r < ADDR_W'(MEM_BYTES));
    we_s        = beat_s & in_range_s & ~err_r;
    widx_s      = addr_r[SZ_MAX +: IDX_W];
  end

  // Burst control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= ID_W'(0);
      bresp   <= 2'b00;
      id_r    <= ID_W'(0);
      len_r   <= LEN_W'(0);
      cnt_r   <= LEN_W'(0);
      size_r  <= 3'd0;
      addr_r  <= ADDR_W'(0);
      burst_r <= 2'b00;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (awvalid && awready) begin
            id_r    <= awid;
            len_r   <= awlen;
            size_r  <= awsize;
            addr_r  <= awaddr;
            burst_r <= awburst;
            cnt_r   <= LEN_W'(0);
            err_r   <= aw_err_s;
            awready <= 1'b0;
            wready  <= 1'b1;
            state_r <= DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        DATA: begin
          if (beat_s) begin
            addr_r <= next_addr_s;
            cnt_r  <= cnt_r + LEN_W'(1);
            err_r  <= err_r | wlast_err_s | ~in_range_s;
            // burst length comes from awlen alone; wlast only flags errors
            if (last_s) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= id_r;
              bresp   <= (err_r | wlast_err_s | ~in_range_s) ? 2'b10 : 2'b00;
              state_r <= RESP;
            end
          end
        end
        RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          awready <= 1'b0;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Byte-lane memory write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BPW; i++) begin
      if (we_s && wstrb[i]) begin
        mem_r[widx_s][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered debug read port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbg_rdata <= DATA_W'(0);
    end else if (32'(dbg_addr) < 32'(MEM_DEPTH)) begin
      dbg_rdata <= mem_r[dbg_addr];
    end else begin
      dbg_rdata <= DATA_W'(0);
    end
  end

endmodule
